// File: rtl/tt_mux4_sel_ctrl.sv
// Break-before-make select sequencer for a LEVELS-deep mux4 tree.
// ena is dropped before sel moves and comes back only after sel has been stable for SETTLE cycles.
module tt_mux4_sel_ctrl #(
    parameter  int LEVELS = 3,
    parameter  int SETTLE = 4,
    localparam int AW     = 2 * LEVELS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_req,
    input  logic          sel_rst,
    input  logic          sel_inc,
    input  logic          sel_load,
    input  logic [AW-1:0] addr_in,
    output logic [AW-1:0] sel,
    output logic          ena,
    output logic          busy,
    output logic          wrap
);

    localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BREAK,
        ST_SETTLE,
        ST_ON
    } state_t;

    typedef struct packed {
        logic [AW-1:0] tgt;
        logic          wrap;
    } req_t;

    state_t        state, state_nxt;
    logic [AW-1:0] tgt;
    logic [AW-1:0] sel_nxt;
    logic [7:0]    cnt, cnt_nxt;
    req_t          req;
    logic          change;

    // Resolve this cycle's request; lower-priority requests are dropped.
    always_comb begin
        req.tgt  = tgt;
        req.wrap = 1'b0;
        if (sel_rst) begin
            req.tgt = '0;
        end else if (sel_load) begin
            req.tgt = addr_in;
        end else if (sel_inc) begin
            req.tgt  = tgt + AW'(1);
            req.wrap = &tgt;
        end
        change = (req.tgt != tgt);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        case (state)
            ST_OFF: begin
                sel_nxt = req.tgt;
                if (en_req) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CNT_INIT;
                end
            end
            ST_SETTLE: begin
                sel_nxt = req.tgt;
                if (!en_req)          state_nxt = ST_OFF;
                else if (change)      cnt_nxt   = CNT_INIT;
                else if (cnt != 8'd0) cnt_nxt   = cnt - 8'd1;
                else                  state_nxt = ST_ON;
            end
            // sel is frozen while the endpoint is live; a change first drops ena.
            ST_ON: begin
                if (!en_req)     state_nxt = ST_OFF;
                else if (change) state_nxt = ST_BREAK;
            end
            ST_BREAK: begin
                sel_nxt = req.tgt;
                if (!en_req) begin
                    state_nxt = ST_OFF;
                end else begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CNT_INIT;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OFF;
            tgt   <= '0;
            cnt   <= '0;
            sel   <= '0;
            ena   <= 1'b0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            tgt   <= req.tgt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            ena   <= (state_nxt == ST_ON);
            busy  <= (state_nxt == ST_BREAK) || (state_nxt == ST_SETTLE);
            wrap  <= req.wrap;
        end
    end

endmodule
